// File: rtl/vector_pkg.sv
// vector_pkg: op encodings and FSM states shared by the sequential vector lane.
package vector_pkg;
    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_XORI   = 4'b0010;
    localparam logic [3:0] OP_MOVI   = 4'b0011;
    localparam logic [3:0] OP_SUB    = 4'b0100;
    localparam logic [3:0] OP_LSL    = 4'b0101;
    localparam logic [3:0] OP_LSR    = 4'b0110;
    localparam logic [3:0] OP_ROR    = 4'b0111;
    localparam logic [3:0] OP_ROL    = 4'b1000;
    localparam logic [3:0] OP_ADDS   = 4'b1001;
    localparam logic [3:0] OP_REDSUM = 4'b1010;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/vector_lane_seq_if.sv
// vector_lane_seq_if: start/busy/done handshake, operands and results of the vector lane.
interface vector_lane_seq_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int RW    = WIDTH + $clog2(LANES)
);
    logic                   start;
    logic [3:0]             op;
    logic [15:0]            imm16;
    logic [11:0]            shamt;
    logic [LANES*WIDTH-1:0] vector_Vs;
    logic [LANES*WIDTH-1:0] vector_Vt;
    logic                   busy;
    logic                   done;
    logic [LANES*WIDTH-1:0] vector_Vd;
    logic [RW-1:0]          red_out;

    modport master (output start, op, imm16, shamt, vector_Vs, vector_Vt,
                    input  busy, done, vector_Vd, red_out);
    modport slave  (input  start, op, imm16, shamt, vector_Vs, vector_Vt,
                    output busy, done, vector_Vd, red_out);
endinterface

// File: rtl/vector_lane_alu.sv
// vector_lane_alu: combinational single-element ALU shared across all lanes.
module vector_lane_alu
    import vector_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] k,
    input  logic [11:0]      shamt,
    output logic [WIDTH-1:0] y
);
    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]      r;
    logic               big;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] rr;
    logic [2*WIDTH-1:0] rl;

    // WIDTH is a power of two, so the low shamt bits give the rotate amount mod WIDTH
    assign r   = shamt[SW-1:0];
    assign big = shamt >= 12'(WIDTH);
    assign sum = {1'b0, a} + {1'b0, b};
    assign rr  = {a, a} >> r;
    assign rl  = {a, a} << r;

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = sum[WIDTH-1:0];
            OP_XORI: y = a ^ k;
            OP_MOVI: y = k;
            OP_SUB:  y = a - b;
            OP_LSL:  y = big ? '0 : a << r;
            OP_LSR:  y = big ? '0 : a >> r;
            OP_ROR:  y = rr[WIDTH-1:0];
            OP_ROL:  y = rl[2*WIDTH-1:WIDTH];
            OP_ADDS: y = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/vector_lane_seq.sv
// vector_lane_seq: walks one shared ALU over the vector elements, one per cycle,
// accumulating a destination vector and a full-precision reduction sum.
module vector_lane_seq
    import vector_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int RW    = WIDTH + $clog2(LANES)
) (
    input logic               clock,
    input logic               reset,
    vector_lane_seq_if.slave  bus
);
    localparam int IW = $clog2(LANES);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [3:0]             op_q, op_d;
    logic [WIDTH-1:0]       k_q, k_d;
    logic [11:0]            shamt_q, shamt_d;
    logic [LANES*WIDTH-1:0] vs_q, vs_d, vt_q, vt_d, vd_q, vd_d;
    logic [RW-1:0]          red_q, red_d;
    logic [WIDTH-1:0]       a, b, y;

    assign a = vs_q[idx_q*WIDTH +: WIDTH];
    assign b = vt_q[idx_q*WIDTH +: WIDTH];

    vector_lane_alu #(.WIDTH(WIDTH)) u_alu (
        .op    (op_q),
        .a     (a),
        .b     (b),
        .k     (k_q),
        .shamt (shamt_q),
        .y     (y)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        k_d     = k_q;
        shamt_d = shamt_q;
        vs_d    = vs_q;
        vt_d    = vt_q;
        vd_d    = vd_q;
        red_d   = red_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                idx_d   = '0;
                op_d    = bus.op;
                k_d     = bus.imm16[WIDTH-1:0];
                shamt_d = bus.shamt;
                vs_d    = bus.vector_Vs;
                vt_d    = bus.vector_Vt;
                vd_d    = '0;
                red_d   = '0;
            end
            RUN: begin
                vd_d[idx_q*WIDTH +: WIDTH] = y;
                if (op_q == OP_REDSUM) red_d = red_q + RW'(a);
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(LANES-1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            k_q     <= '0;
            shamt_q <= '0;
            vs_q    <= '0;
            vt_q    <= '0;
            vd_q    <= '0;
            red_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            k_q     <= k_d;
            shamt_q <= shamt_d;
            vs_q    <= vs_d;
            vt_q    <= vt_d;
            vd_q    <= vd_d;
            red_q   <= red_d;
        end
    end

    assign bus.busy      = state_q == RUN;
    assign bus.done      = state_q == DONE;
    assign bus.vector_Vd = vd_q;
    assign bus.red_out   = red_q;
endmodule
